// File: rtl/rv32im_ifu_pkg.sv
// rtl/rv32im_ifu_pkg.sv - shared widths, IFU state encoding and fetch constants
package rv32im_ifu_pkg;

    parameter int unsigned API_ADDR_WIDTH = 32;
    parameter int unsigned API_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IFU_S_REQ  = 2'd0,
        IFU_S_WAIT = 2'd1,
        IFU_S_HALT = 2'd2
    } ifu_state_e;

    parameter logic [31:0] RV_NOP  = 32'h0000_0013;
    parameter int unsigned PC_STEP = 4;

endpackage

// File: rtl/rv32im_ifu_buf.sv
// rtl/rv32im_ifu_buf.sv - one-entry valid/ready output register {instr, pc, fault} with flush
module rv32im_ifu_buf #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          load_i,
    input  logic [DW-1:0] load_instr_i,
    input  logic [AW-1:0] load_pc_i,
    input  logic          load_fault_i,
    input  logic          flush_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] instr_o,
    output logic [AW-1:0] pc_o,
    output logic          fault_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] instr_q;
    logic [AW-1:0] pc_q;
    logic          fault_q;

    // A load wins over flush so a redirect can deposit a fault entry on the same edge.
    always_comb begin
        valid_d = valid_q;
        if (load_i) begin
            valid_d = 1'b1;
        end else if (flush_i || (ready_i && valid_q)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load_i) begin
                instr_q <= load_instr_i;
                pc_q    <= load_pc_i;
                fault_q <= load_fault_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign fault_o = fault_q;

endmodule

// File: rtl/rv32im_ifu.sv
// rtl/rv32im_ifu.sv - instruction fetch unit: PC, single-outstanding fetch FSM, redirect handling
module rv32im_ifu
    import rv32im_ifu_pkg::*;
#(
    parameter int unsigned          API_ADDR_WIDTH = rv32im_ifu_pkg::API_ADDR_WIDTH,
    parameter int unsigned          API_DATA_WIDTH = rv32im_ifu_pkg::API_DATA_WIDTH,
    parameter logic [API_ADDR_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    output logic                      imem_req_valid_o,
    input  logic                      imem_req_ready_i,
    output logic [API_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                      imem_resp_valid_i,
    input  logic [API_DATA_WIDTH-1:0] imem_resp_data_i,
    input  logic                      imem_resp_err_i,
    input  logic                      redirect_valid_i,
    input  logic [API_ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                      instr_valid_o,
    input  logic                      instr_ready_i,
    output logic [API_DATA_WIDTH-1:0] instr_o,
    output logic [API_ADDR_WIDTH-1:0] instr_pc_o,
    output logic                      instr_fault_o
);

    ifu_state_e                state_q, state_d;
    logic [API_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                      drop_q, drop_d;

    logic                      buf_load, buf_flush, buf_fault;
    logic [API_DATA_WIDTH-1:0] buf_instr;
    logic [API_ADDR_WIDTH-1:0] buf_pc;
    logic                      space;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IFU_S_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;
        buf_instr = imem_resp_data_i;
        buf_pc    = pc_q;
        buf_fault = 1'b0;
        if (redirect_valid_i) begin
            pc_d      = redirect_pc_i;
            buf_flush = 1'b1;
            // An unanswered fetch stays outstanding; remember to swallow its response.
            if (state_q == IFU_S_WAIT && !imem_resp_valid_i) begin
                drop_d  = 1'b1;
                state_d = IFU_S_WAIT;
            end else begin
                if (imem_resp_valid_i) drop_d = 1'b0;
                state_d = IFU_S_REQ;
            end
            if (redirect_pc_i[1:0] != 2'b00) begin
                buf_load  = 1'b1;
                buf_instr = API_DATA_WIDTH'(RV_NOP);
                buf_pc    = redirect_pc_i;
                buf_fault = 1'b1;
                state_d   = IFU_S_HALT;
            end
        end else begin
            case (state_q)
                IFU_S_REQ: begin
                    if (imem_req_valid_o && imem_req_ready_i) state_d = IFU_S_WAIT;
                end
                IFU_S_WAIT: begin
                    if (imem_resp_valid_i) begin
                        state_d = IFU_S_REQ;
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else begin
                            buf_load  = 1'b1;
                            buf_fault = imem_resp_err_i;
                            if (imem_resp_err_i) begin
                                buf_instr = API_DATA_WIDTH'(RV_NOP);
                                state_d   = IFU_S_HALT;
                            end else begin
                                pc_d = pc_q + API_ADDR_WIDTH'(PC_STEP);
                            end
                        end
                    end
                end
                IFU_S_HALT: begin
                    if (imem_resp_valid_i) drop_d = 1'b0;
                end
                default: state_d = IFU_S_REQ;
            endcase
        end
    end

    always_comb begin
        space            = !instr_valid_o || instr_ready_i;
        imem_req_valid_o = rst_n_i && (state_q == IFU_S_REQ) && space && !redirect_valid_i;
        imem_addr_o      = pc_q;
    end

    rv32im_ifu_buf #(
        .AW(API_ADDR_WIDTH),
        .DW(API_DATA_WIDTH)
    ) u_buf (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .load_i       (buf_load),
        .load_instr_i (buf_instr),
        .load_pc_i    (buf_pc),
        .load_fault_i (buf_fault),
        .flush_i      (buf_flush),
        .ready_i      (instr_ready_i),
        .valid_o      (instr_valid_o),
        .instr_o      (instr_o),
        .pc_o         (instr_pc_o),
        .fault_o      (instr_fault_o)
    );

endmodule

// File: tb/tb_rv32im_ifu.sv
// tb/tb_rv32im_ifu.sv - directed bench for rv32im_ifu with a latency-programmable memory responder
module tb_rv32im_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;

    int          n_checks = 0;
    int          n_errors = 0;

    int          lat;
    logic [31:0] err_addr;
    logic [31:0] reqlog[$];
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    logic        hs;
    logic [31:0] hs_addr;
    int          n_req;

    always #5 clk = ~clk;

    rv32im_ifu dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .imem_req_valid_o  (req_valid),
        .imem_req_ready_i  (req_ready),
        .imem_addr_o       (addr),
        .imem_resp_valid_i (resp_valid),
        .imem_resp_data_i  (resp_data),
        .imem_resp_err_i   (resp_err),
        .redirect_valid_i  (redirect_valid),
        .redirect_pc_i     (redirect_pc),
        .instr_valid_o     (instr_valid),
        .instr_ready_i     (instr_ready),
        .instr_o           (instr),
        .instr_pc_o        (instr_pc),
        .instr_fault_o     (instr_fault)
    );

    // Memory: word = {C0DE, addr[15:0]}; response presented lat cycles after acceptance.
    always @(posedge clk) begin
        hs      = rst_n && req_valid && req_ready;
        hs_addr = addr;
        #2;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (hs) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = hs_addr;
                reqlog.push_back(hs_addr);
            end
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    resp_valid = 1'b1;
                    resp_data  = {16'hC0DE, paddr[15:0]};
                    resp_err   = (paddr == err_addr);
                    pend       = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_log[10];
        exp_log = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104, 32'h200, 32'h20, 32'h40, 32'hFFFF_FFFC};
        rst_n          = 1'b0;
        req_ready      = 1'b1;
        resp_valid     = 1'b0;
        resp_data      = '0;
        resp_err       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        lat            = 1;
        err_addr       = 32'h1;
        pend           = 1'b0;
        cnt            = 0;
        paddr          = '0;

        repeat (2) tick;
        check("rst_req_valid", {31'b0, req_valid}, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_fault", {31'b0, instr_fault}, 32'h0);

        // Free run, 1-cycle memory
        rst_n = 1'b1;
        #1;
        check("run_cyc1_valid", {31'b0, instr_valid}, 32'h0);
        check("run_cyc1_req", {31'b0, req_valid}, 32'h1);
        tick;
        check("run_cyc2_valid", {31'b0, instr_valid}, 32'h0);
        tick;
        check("run_cyc3_valid", {31'b0, instr_valid}, 32'h1);
        check("run_pc0", instr_pc, 32'h0);
        check("run_instr0", instr, 32'hC0DE_0000);
        tick;
        check("run_gap_valid", {31'b0, instr_valid}, 32'h0);
        tick;
        check("run_pc4", instr_pc, 32'h4);
        check("run_instr4", instr, 32'hC0DE_0004);
        tick;
        tick;
        check("run_pc8", instr_pc, 32'h8);
        check("run_instr8", instr, 32'hC0DE_0008);

        // Decoder backpressure
        instr_ready = 1'b0;
        repeat (5) begin
            tick;
            check("bp_req_valid", {31'b0, req_valid}, 32'h0);
            check("bp_valid", {31'b0, instr_valid}, 32'h1);
            check("bp_pc", instr_pc, 32'h8);
            check("bp_instr", instr, 32'hC0DE_0008);
        end
        instr_ready = 1'b1;
        lat         = 3;
        #1;
        check("bp_release_req", {31'b0, req_valid}, 32'h1);
        check("bp_release_addr", addr, 32'hC);

        // Redirect while waiting; response 2 cycles later is dropped
        tick;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick;
        redirect_valid = 1'b0;
        lat            = 1;
        check("drop_valid_a", {31'b0, instr_valid}, 32'h0);
        tick;
        check("drop_valid_b", {31'b0, instr_valid}, 32'h0);
        check("drop_req_wait", {31'b0, req_valid}, 32'h0);
        tick;
        check("drop_valid_c", {31'b0, instr_valid}, 32'h0);
        check("drop_req", {31'b0, req_valid}, 32'h1);
        check("drop_addr", addr, 32'h100);
        tick;
        tick;
        check("tgt_pc", instr_pc, 32'h100);
        check("tgt_instr", instr, 32'hC0DE_0100);

        // Redirect coincident with response, decoder ready
        tick;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick;
        check("coinc_valid", {31'b0, instr_valid}, 32'h0);
        redirect_valid = 1'b0;
        #1;
        check("coinc_req", {31'b0, req_valid}, 32'h1);
        check("coinc_addr", addr, 32'h200);
        tick;
        tick;
        check("coinc_pc", instr_pc, 32'h200);
        check("coinc_instr", instr, 32'hC0DE_0200);

        // Flush of a held entry, then bus error at 0x20
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        err_addr       = 32'h20;
        #1;
        check("redir_req_suppressed", {31'b0, req_valid}, 32'h0);
        tick;
        check("flush_valid", {31'b0, instr_valid}, 32'h0);
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        tick;
        tick;
        check("berr_valid", {31'b0, instr_valid}, 32'h1);
        check("berr_fault", {31'b0, instr_fault}, 32'h1);
        check("berr_pc", instr_pc, 32'h20);
        check("berr_instr", instr, 32'h0000_0013);
        instr_ready = 1'b0;
        n_req       = reqlog.size();
        repeat (3) begin
            tick;
            check("halt_req", {31'b0, req_valid}, 32'h0);
            check("halt_fault_held", {31'b0, instr_fault}, 32'h1);
        end
        instr_ready = 1'b1;
        tick;
        tick;
        check("halt_consumed", {31'b0, instr_valid}, 32'h0);
        check("halt_req_free", {31'b0, req_valid}, 32'h0);
        check("halt_no_reqs", reqlog.size(), n_req);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick;
        redirect_valid = 1'b0;
        #1;
        check("resume_req", {31'b0, req_valid}, 32'h1);
        check("resume_addr", addr, 32'h40);
        tick;
        tick;
        check("resume_pc", instr_pc, 32'h40);
        check("resume_instr", instr, 32'hC0DE_0040);
        check("resume_fault", {31'b0, instr_fault}, 32'h0);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        #1;
        check("mis_req_suppressed", {31'b0, req_valid}, 32'h0);
        tick;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        #1;
        check("mis_valid", {31'b0, instr_valid}, 32'h1);
        check("mis_fault", {31'b0, instr_fault}, 32'h1);
        check("mis_pc", instr_pc, 32'h102);
        check("mis_instr", instr, 32'h0000_0013);
        check("mis_req", {31'b0, req_valid}, 32'h0);
        n_req = reqlog.size();
        tick;
        tick;
        check("mis_halt_req", {31'b0, req_valid}, 32'h0);
        check("mis_no_reqs", reqlog.size(), n_req);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        instr_ready    = 1'b1;
        tick;
        redirect_valid = 1'b0;
        #1;
        check("wrap_req", {31'b0, req_valid}, 32'h1);
        check("wrap_addr", addr, 32'hFFFF_FFFC);
        tick;
        tick;
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_instr", instr, 32'hC0DE_FFFC);
        check("wrap_next_req", {31'b0, req_valid}, 32'h1);
        check("wrap_next_addr", addr, 32'h0);

        check("reqlog_size", reqlog.size(), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < reqlog.size()) check($sformatf("reqlog_%0d", i), reqlog[i], exp_log[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
